// File: rtl/out_mem_arbiter_if.sv
// Bundle between the two output-image requesters, the arbiter and the single-port image memory.
// slave: arbiter view; master: requesters plus memory model view.
interface out_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 8
);
    logic              req0, req1;
    logic              we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              lock0, lock1;
    logic              gnt0, gnt1;
    logic              rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/out_mem_arbiter.sv
// Round-robin arbiter with bounded lock for the single-port output image memory;
// port 0 = grayscale write-back, port 1 = error-diffusion read/modify/write engine.
module out_mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 8,
    parameter int MAX_LOCK = 8
) (
    input logic clk,
    input logic rst,
    out_mem_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W:0] LOCK_LIMIT = (CNT_W + 1)'(MAX_LOCK);

    logic             prio;
    logic             lock_owner_vld;
    logic [CNT_W-1:0] lock_cnt;
    logic             rd_pend_p1;
    logic             rd_port_p1;
    logic             rvalid0_p2, rvalid1_p2;
    logic [DATA_W-1:0] rdata0_p2, rdata1_p2;

    logic              win0, win1, issue, read_issue;
    logic              lock_win, keep_prio;
    logic [CNT_W:0]    cnt_next;
    logic              we_mux;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;

    // A grant to the peer of the current lock owner starts a fresh count rather than
    // inheriting the owner's progress toward forced release.
    function automatic logic [CNT_W:0] lock_count_next(input logic owner_match,
                                                       input logic [CNT_W-1:0] cnt);
        return owner_match ? ({1'b0, cnt} + (CNT_W + 1)'(1)) : (CNT_W + 1)'(1);
    endfunction

    always_comb begin
        win0       = bus.req0 & (~bus.req1 | ~prio);
        win1       = bus.req1 & (~bus.req0 | prio);
        issue      = win0 | win1;
        we_mux     = win1 ? bus.we1 : (win0 & bus.we0);
        addr_mux   = win1 ? bus.addr1 : bus.addr0;
        wdata_mux  = win1 ? bus.wdata1 : bus.wdata0;
        read_issue = issue & ~we_mux;
        lock_win   = win1 ? bus.lock1 : bus.lock0;
        cnt_next   = lock_count_next(lock_owner_vld & (prio == win1), lock_cnt);
        keep_prio  = lock_win & (cnt_next < LOCK_LIMIT);
    end

    assign bus.gnt0      = win0;
    assign bus.gnt1      = win1;
    assign bus.mem_en    = issue;
    assign bus.mem_we    = we_mux;
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_wdata = wdata_mux;
    assign bus.rvalid0   = rvalid0_p2;
    assign bus.rvalid1   = rvalid1_p2;
    assign bus.rdata0    = rdata0_p2;
    assign bus.rdata1    = rdata1_p2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio           <= 1'b0;
            lock_owner_vld <= 1'b0;
            lock_cnt       <= '0;
            rd_pend_p1     <= 1'b0;
            rd_port_p1     <= 1'b0;
            rvalid0_p2     <= 1'b0;
            rvalid1_p2     <= 1'b0;
            rdata0_p2      <= '0;
            rdata1_p2      <= '0;
        end else begin
            if (issue) begin
                if (keep_prio) begin
                    prio           <= win1;
                    lock_cnt       <= cnt_next[CNT_W-1:0];
                    lock_owner_vld <= 1'b1;
                end else begin
                    prio           <= ~win1;
                    lock_cnt       <= '0;
                    lock_owner_vld <= 1'b0;
                end
            end
            // p1: read issued last cycle, memory data arriving now
            rd_pend_p1 <= read_issue;
            rd_port_p1 <= win1;
            // p2: data captured and tagged to the issuing port
            rvalid0_p2 <= rd_pend_p1 & ~rd_port_p1;
            rvalid1_p2 <= rd_pend_p1 & rd_port_p1;
            if (rd_pend_p1 & ~rd_port_p1) rdata0_p2 <= bus.mem_rdata;
            if (rd_pend_p1 & rd_port_p1)  rdata1_p2 <= bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_out_mem_arbiter.sv
// Directed bench for out_mem_arbiter: grant checks per step plus a read-return scoreboard
// fed by a simple registered memory model.
module tb_out_mem_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 8;

    typedef struct packed {
        int         due;
        logic       port;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];
    logic [7:0] mem [256];

    out_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    out_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered single-port memory: read data valid the cycle after issue.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
            else bus.mem_rdata <= mem[bus.mem_addr[7:0]];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: push on each read grant, compare when due, otherwise no rvalid allowed.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            chk("rst_rvalid0", bus.rvalid0, 1'b0);
            chk("rst_rvalid1", bus.rvalid1, 1'b0);
        end else begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                chk(sb[0].port ? "sb_rvalid1" : "sb_rvalid0",
                    sb[0].port ? bus.rvalid1 : bus.rvalid0, 1'b1);
                chk(sb[0].port ? "sb_other_rvalid0" : "sb_other_rvalid1",
                    sb[0].port ? bus.rvalid0 : bus.rvalid1, 1'b0);
                chk(sb[0].port ? "sb_rdata1" : "sb_rdata0",
                    sb[0].port ? bus.rdata1 : bus.rdata0, sb[0].data);
                void'(sb.pop_front());
            end else begin
                chk("idle_rvalid0", bus.rvalid0, 1'b0);
                chk("idle_rvalid1", bus.rvalid1, 1'b0);
            end
            if (bus.gnt0 && !bus.we0) sb.push_back('{due: cyc + 2, port: 1'b0, data: mem[bus.addr0[7:0]]});
            if (bus.gnt1 && !bus.we1) sb.push_back('{due: cyc + 2, port: 1'b1, data: mem[bus.addr1[7:0]]});
        end
    end

    task automatic drive0(input logic r, input logic w, input logic [31:0] a, input logic [7:0] d, input logic l);
        bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d; bus.lock0 = l;
    endtask

    task automatic drive1(input logic r, input logic w, input logic [31:0] a, input logic [7:0] d, input logic l);
        bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d; bus.lock1 = l;
    endtask

    task automatic step_begin();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[7] = 8'h3C;
        bus.mem_rdata = '0;
        drive0(1'b0, 1'b0, 32'd0, 8'h00, 1'b0);
        drive1(1'b0, 1'b0, 32'd0, 8'h00, 1'b0);

        // Reset state
        @(negedge clk);
        chk("reset_gnt0", bus.gnt0, 1'b0);
        chk("reset_mem_en", bus.mem_en, 1'b0);
        chk("reset_rdata0", bus.rdata0, 8'h00);
        chk("reset_rdata1", bus.rdata1, 8'h00);
        step_begin();
        rst = 1'b0;

        // 1: single write from port 0
        step_begin();
        drive0(1'b1, 1'b1, 32'd5, 8'hA0, 1'b0);
        @(negedge clk);
        chk("t1_gnt0", bus.gnt0, 1'b1);
        chk("t1_gnt1", bus.gnt1, 1'b0);
        chk("t1_mem_en", bus.mem_en, 1'b1);
        chk("t1_mem_we", bus.mem_we, 1'b1);
        chk("t1_mem_addr", bus.mem_addr, 32'd5);
        chk("t1_mem_wdata", bus.mem_wdata, 8'hA0);
        step_begin();
        drive0(1'b0, 1'b0, 32'd0, 8'h00, 1'b0);
        @(negedge clk);
        chk("idle_mem_en", bus.mem_en, 1'b0);
        chk("idle_mem_we", bus.mem_we, 1'b0);

        // 3: port 1 read of addr 7, data returns two cycles later (also hands prio to port 0)
        step_begin();
        drive1(1'b1, 1'b0, 32'd7, 8'h00, 1'b0);
        @(negedge clk);
        chk("t3_gnt1", bus.gnt1, 1'b1);
        chk("t3_gnt0", bus.gnt0, 1'b0);
        chk("t3_mem_we", bus.mem_we, 1'b0);
        chk("t3_mem_addr", bus.mem_addr, 32'd7);
        step_begin();
        drive1(1'b0, 1'b0, 32'd0, 8'h00, 1'b0);
        step_begin();
        @(negedge clk);
        chk("t3_rvalid1", bus.rvalid1, 1'b1);
        chk("t3_rdata1", bus.rdata1, 8'h3C);
        chk("t3_rvalid0", bus.rvalid0, 1'b0);

        // 2: contention without lock alternates 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            step_begin();
            drive0(1'b1, 1'b1, 32'd16 + 32'(i), 8'h10 + 8'(i), 1'b0);
            drive1(1'b1, 1'b1, 32'd32 + 32'(i), 8'h20 + 8'(i), 1'b0);
            @(negedge clk);
            chk($sformatf("t2_gnt0_%0d", i), bus.gnt0, (i % 2) == 0);
            chk($sformatf("t2_gnt1_%0d", i), bus.gnt1, (i % 2) == 1);
            chk($sformatf("t2_addr_%0d", i), bus.mem_addr, (i % 2) == 0 ? 32'd16 + 32'(i) : 32'd32 + 32'(i));
        end
        step_begin();
        drive1(1'b0, 1'b0, 32'd0, 8'h00, 1'b0);
        @(negedge clk);
        chk("t4_pre_gnt0", bus.gnt0, 1'b1);

        // 4: port 1 locked burst, forced release after 8 grants
        for (int i = 0; i < 10; i++) begin
            step_begin();
            drive0(1'b1, 1'b1, 32'd48, 8'h30, 1'b0);
            drive1(1'b1, 1'b1, 32'd64 + 32'(i), 8'h40 + 8'(i), 1'b1);
            @(negedge clk);
            chk($sformatf("t4_gnt1_%0d", i), bus.gnt1, i != 8);
            chk($sformatf("t4_gnt0_%0d", i), bus.gnt0, i == 8);
        end

        // 5: back-to-back reads, port 1 then port 0
        step_begin();
        drive0(1'b0, 1'b0, 32'd0, 8'h00, 1'b0);
        drive1(1'b1, 1'b0, 32'd9, 8'h00, 1'b0);
        @(negedge clk);
        chk("t5_gnt1", bus.gnt1, 1'b1);
        step_begin();
        drive1(1'b0, 1'b0, 32'd0, 8'h00, 1'b0);
        drive0(1'b1, 1'b0, 32'd3, 8'h00, 1'b0);
        @(negedge clk);
        chk("t5_gnt0", bus.gnt0, 1'b1);
        step_begin();
        drive0(1'b0, 1'b0, 32'd0, 8'h00, 1'b0);
        @(negedge clk);
        chk("t5_rvalid1", bus.rvalid1, 1'b1);
        chk("t5_rdata1", bus.rdata1, 8'h09 ^ 8'h5A);
        step_begin();
        @(negedge clk);
        chk("t5_rvalid0", bus.rvalid0, 1'b1);
        chk("t5_rdata0", bus.rdata0, 8'h03 ^ 8'h5A);
        chk("t5_rvalid1_off", bus.rvalid1, 1'b0);
        chk("t5_rdata1_hold", bus.rdata1, 8'h09 ^ 8'h5A);

        // 6: reset the cycle after a read grant discards the read
        step_begin();
        drive0(1'b1, 1'b0, 32'd3, 8'h00, 1'b0);
        @(negedge clk);
        chk("t6_gnt0", bus.gnt0, 1'b1);
        step_begin();
        drive0(1'b0, 1'b0, 32'd0, 8'h00, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rdata0_cleared", bus.rdata0, 8'h00);
        chk("t6_rdata1_cleared", bus.rdata1, 8'h00);
        step_begin();
        step_begin();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step_begin();
        drive0(1'b1, 1'b1, 32'd80, 8'h55, 1'b0);
        drive1(1'b1, 1'b1, 32'd81, 8'h66, 1'b0);
        @(negedge clk);
        chk("t6_post_gnt0", bus.gnt0, 1'b1);
        chk("t6_post_gnt1", bus.gnt1, 1'b0);
        step_begin();
        drive0(1'b0, 1'b0, 32'd0, 8'h00, 1'b0);
        drive1(1'b0, 1'b0, 32'd0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) step_begin();
        @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
